cordic_atan2: RTL and testbench

Iterative vectoring-mode CORDIC: converts a Cartesian vector (x, y) into a polar angle atan2(y, x) in the same Q2.14 radian format that the rotation CORDIC `cordic` takes as input, and into a gain-corrected magnitude. It sits on the analysis side of the synth path, for example for phase recovery and feedback of oscillator state. It shares the arctangent table and fixed-point constants with `cordic`. One input is processed at a time over 16 micro-rotations, using valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_vec_step.sv | 37 +++
 rtl/cordic_atan2.sv | 133 +++++++++++++
 tb/tb_cordic_atan2.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, arctangent table and vectoring FSM states.
// Q2.14 fixed point throughout.
package cordic_pkg;

  localparam int CORDIC_NTAB = 16;

  localparam logic [15:0] ATAN_TABLE [0:15] = '{
    16'h3243, 16'h1DAC, 16'h0FAD, 16'h07F5,
    16'h03FE, 16'h01FF, 16'h00FF, 16'h007F,
    16'h003F, 16'h001F, 16'h000F, 16'h0007,
    16'h0003, 16'h0001, 16'h0000, 16'h0000
  };

  localparam logic signed [15:0] CORDIC_1K = 16'sh26DD;
  localparam logic [15:0] HALF_PI = 16'h6487;
  localparam logic [15:0] PI = 16'hC90F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_SCALE,
    ST_DONE
  } cordic_atan2_state_t;

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring micro-rotation: drives y toward zero.
// Purely combinational, reused every iteration.
module cordic_vec_step (
  input  logic signed [17:0] x,
  input  logic signed [17:0] y,
  input  logic signed [31:0] z,
  input  logic        [3:0]  i,
  input  logic        [15:0] t,
  output logic signed [17:0] x_nx,
  output logic signed [17:0] y_nx,
  output logic signed [31:0] z_nx
);

  logic signed [17:0] xs;
  logic signed [17:0] ys;
  logic signed [31:0] tz;

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign tz = {16'd0, t};

  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    if (!y[17]) begin
      x_nx = x + ys;
      y_nx = y - xs;
      z_nx = z + tz;
    end else begin
      x_nx = x - ys;
      y_nx = y + xs;
      z_nx = z - tz;
    end
  end

endmodule

// File: rtl/cordic_atan2.sv
// Iterative vectoring CORDIC: (x, y) -> atan2 angle and
// gain-corrected magnitude, one vector at a time.
module cordic_atan2
  import cordic_pkg::*;
#(
  parameter int NITER = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] angle_out,
  output logic [15:0] mag_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic signed [31:0] PI_S = {16'd0, PI};
  localparam logic signed [31:0] HP_S = {16'd0, HALF_PI};

  cordic_atan2_state_t state_q, state_d;

  logic signed [17:0] x_q, y_q;
  logic signed [31:0] z_q;
  logic        [3:0]  i_q;
  logic               zero_q;

  logic signed [17:0] x_nx, y_nx;
  logic signed [31:0] z_nx;
  logic signed [17:0] xs, ys;
  logic signed [33:0] prod;
  logic signed [31:0] z_sat;
  logic               accept;
  logic               last_iter;
  logic               unused_prod;

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign last_iter = (i_q == 4'(NITER - 1));

  assign xs = {{2{x_in[15]}}, x_in};
  assign ys = {{2{y_in[15]}}, y_in};

  cordic_vec_step u_step (
    .x    (x_q),
    .y    (y_q),
    .z    (z_q),
    .i    (i_q),
    .t    (ATAN_TABLE[i_q]),
    .x_nx (x_nx),
    .y_nx (y_nx),
    .z_nx (z_nx)
  );

  assign prod = $signed({{16{x_q[17]}}, x_q})
              * $signed({{18{CORDIC_1K[15]}}, CORDIC_1K});
  assign unused_prod = ^{prod[33:30], prod[13:0]};

  // Residual overshoot near +/-PI must not wrap the angle
  always_comb begin
    z_sat = z_q;
    if (z_q > PI_S)
      z_sat = PI_S;
    else if (z_q < -PI_S)
      z_sat = -PI_S;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ITER;
      ST_ITER:  if (last_iter) state_d = ST_SCALE;
      ST_SCALE: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      zero_q    <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            i_q    <= '0;
            zero_q <= (x_in == 16'd0) && (y_in == 16'd0);
            if (!x_in[15]) begin
              x_q <= xs;
              y_q <= ys;
              z_q <= '0;
            end else if (!y_in[15]) begin
              x_q <= ys;
              y_q <= -xs;
              z_q <= HP_S;
            end else begin
              x_q <= -ys;
              y_q <= xs;
              z_q <= -HP_S;
            end
          end
        end
        ST_ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          i_q <= i_q + 4'd1;
        end
        ST_SCALE: begin
          angle_out <= zero_q ? 32'd0 : z_sat;
          mag_out   <= zero_q ? 16'd0 : prod[29:14];
          out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2.sv
// Directed bench for cordic_atan2: angles, magnitudes,
// latency, output stall and mid-operation reset.
module tb_cordic_atan2;

  logic        clock;
  logic        reset;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle_out;
  logic [15:0] mag_out;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;

  cordic_atan2 #(.NITER(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .x_in      (x_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Present one vector, return latency and sampled result
  task automatic run_vec(input logic [15:0] xv,
                         input logic [15:0] yv,
                         output int lat,
                         output int ang,
                         output int mag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    x_in = xv;
    y_in = yv;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    x_in = 16'h5A5A;
    y_in = 16'hA5A5;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    ang = $signed(angle_out);
    mag = int'(mag_out);
  endtask

  task automatic take_result;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (angle_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_angle got %h want 0", angle_out);
    end
    checks++;
    if (mag_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_mag got %h want 0", mag_out);
    end
  endtask

  task automatic test_axes;
    int lat, ang, mag;
    run_vec(16'h4000, 16'h0000, lat, ang, mag);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL px_latency got %0d want 17", lat);
    end
    checks++;
    if (absd(ang, 0) > 4) begin
      errors++;
      $display("FAIL px_angle got %0d want 0+-4", ang);
    end
    checks++;
    if (absd(mag, 16384) > 4) begin
      errors++;
      $display("FAIL px_mag got %0d want 16384+-4", mag);
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL px_take got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end

    run_vec(16'h0000, 16'h4000, lat, ang, mag);
    checks++;
    if (absd(ang, 25735) > 8) begin
      errors++;
      $display("FAIL py_angle got %0d want 25735+-8", ang);
    end
    checks++;
    if (absd(mag, 16384) > 8) begin
      errors++;
      $display("FAIL py_mag got %0d want 16384+-8", mag);
    end
    take_result();

    run_vec(16'hC000, 16'h0000, lat, ang, mag);
    checks++;
    if (absd(ang, 51471) > 8) begin
      errors++;
      $display("FAIL nx_angle got %0d want 51471+-8", ang);
    end
    checks++;
    if (absd(mag, 16384) > 8) begin
      errors++;
      $display("FAIL nx_mag got %0d want 16384+-8", mag);
    end
    take_result();
  endtask

  task automatic test_diag;
    int lat, ang, mag;
    run_vec(16'h4000, 16'h4000, lat, ang, mag);
    checks++;
    if (absd(ang, 12867) > 8) begin
      errors++;
      $display("FAIL d1_angle got %0d want 12867+-8", ang);
    end
    checks++;
    if (absd(mag, 23170) > 8) begin
      errors++;
      $display("FAIL d1_mag got %0d want 23170+-8", mag);
    end
    take_result();

    run_vec(16'h8000, 16'h8000, lat, ang, mag);
    checks++;
    if (absd(ang, -38604) > 8) begin
      errors++;
      $display("FAIL d3_angle got %0d want -38604+-8", ang);
    end
    checks++;
    if (absd(mag, 46341) > 8) begin
      errors++;
      $display("FAIL d3_mag got %0d want 46341+-8", mag);
    end
    take_result();
  endtask

  task automatic test_zero;
    int lat, ang, mag;
    run_vec(16'h0000, 16'h0000, lat, ang, mag);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL zero_latency got %0d want 17", lat);
    end
    checks++;
    if (ang !== 0 || mag !== 0) begin
      errors++;
      $display("FAIL zero_result got a=%0d m=%0d want 0 0",
               ang, mag);
    end
    take_result();
  endtask

  task automatic test_stall;
    int lat, ang, mag;
    logic [31:0] a0;
    logic [15:0] m0;
    run_vec(16'h4000, 16'h4000, lat, ang, mag);
    a0 = angle_out;
    m0 = mag_out;
    x_in = 16'h0000;
    y_in = 16'h4000;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          angle_out !== a0 || mag_out !== m0) begin
        errors++;
        $display("FAIL stall_hold c%0d got v=%b r=%b a=%h m=%h want v=1 r=0 a=%h m=%h",
                 k, out_valid, in_ready, angle_out, mag_out, a0, m0);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_xfer got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept got r=%b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    ang = $signed(angle_out);
    checks++;
    if (lat !== 17 || absd(ang, 25735) > 8) begin
      errors++;
      $display("FAIL stall_second got lat=%0d a=%0d want 17 25735+-8",
               lat, ang);
    end
    take_result();
  endtask

  task automatic test_reset_mid;
    int lat, ang, mag;
    bit stale;
    x_in = 16'h4000;
    y_in = 16'h4000;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        angle_out !== 32'd0 || mag_out !== 16'd0) begin
      errors++;
      $display("FAIL midreset got v=%b r=%b a=%h m=%h want 0 1 0 0",
               out_valid, in_ready, angle_out, mag_out);
    end
    @(negedge clock);
    reset = 1'b1;
    stale = 1'b0;
    repeat (25) begin
      @(posedge clock); #1;
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale got out_valid=1 want 0");
    end
    run_vec(16'h4000, 16'h0000, lat, ang, mag);
    checks++;
    if (lat !== 17 || absd(ang, 0) > 4 ||
        absd(mag, 16384) > 4) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d a=%0d m=%0d want 17 0 16384",
               lat, ang, mag);
    end
    take_result();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    x_in = '0;
    y_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    test_axes();
    test_diag();
    test_zero();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
